out_port_bcd_seg: RTL and testbench
===================================

# out_port_bcd_seg

- Parametrised successor to the fixed two-digit output-port display path.
- Converts `NUM_CH` binary output ports of `DATA_W` bits each into `DIGITS` decimal seven-segment digits per channel.
- Uses one shared serial double-dabble engine, scanned round-robin across channels, so any width and digit count is supported with one adder set.
- Sits between the CPU's `out_port` buses and the board `HEX` pins; adds per-channel overflow flags and refresh handshaking that the fixed path lacks.

## Interface
Parameters:
- `NUM_CH`, 3: number of output-port channels.
- `DATA_W`, 32: width of each port value.
- `DIGITS`, 2: decimal digits displayed per channel.
- `ACTIVE_LOW`, 1: 1 = segment on at 0 (board HEX); 0 = segment on at 1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: refresh enable.
- `port_in` in `NUM_CH*DATA_W`: channel k is `[k*DATA_W +: DATA_W]`.
- `hex_out` out `NUM_CH*DIGITS*7`: channel k, digit d (d=0 is least significant) at `[(k*DIGITS+d)*7 +: 7]`. Bit order is gfedcba, bit0 = a.
- `ovf` out `NUM_CH`: channel value ≥ 10^DIGITS.
- `busy` out 1: conversion in progress.
- `update_done` out 1: one-cycle pulse after the last channel's digits are stored.

## Operation
- FSM states: IDLE, LOAD, SHIFT, STORE.
- IDLE → LOAD when `en`=1; stays in IDLE otherwise.
- LOAD (1 cycle):
  - Samples `port_in[ch]` into the binary shift register.
  - Clears the `DIGITS*4`-bit BCD accumulator and the carry flag.
  - Later changes to `port_in` are ignored until the next LOAD of that channel.
- SHIFT (exactly `DATA_W` cycles), each cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {BCD, bin} shifts left by 1.
  - The bit shifted out of the top nibble ORs into a sticky carry.
- STORE (1 cycle):
  - Registers the decoded digits into channel `ch`'s slice of `hex_out`.
  - Writes the carry to `ovf[ch]`.
- After STORE:
  - If `ch`<NUM_CH-1: `ch`+1, then LOAD if `en`, else IDLE.
  - If last channel: `ch`=0, `update_done` pulses, then LOAD if `en`, else IDLE.
- Displayed value is (value mod 10^DIGITS). `ovf`=1 exactly when value ≥ 10^DIGITS.
- Digit patterns (ACTIVE_LOW=1), 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank is 7F. ACTIVE_LOW=0 inverts all patterns.
- `busy`=1 in LOAD, SHIFT and STORE; 0 in IDLE.
- `en` falling mid-channel: the current channel completes and stores, then the FSM idles. All outputs hold.
- Reset at any time aborts the conversion. On the next cycle:
  - state IDLE, `ch`=0;
  - `hex_out` all blank, `ovf`=0, `busy`=0, `update_done`=0.

## Timing
- Per channel: DATA_W+2 cycles. Full refresh: NUM_CH*(DATA_W+2), which is 102 at defaults.
- With `en` held high from reset release, the first `update_done` is in cycle 1+NUM_CH*(DATA_W+2) after release, i.e. cycle 103.
- Steady-state `update_done` period: NUM_CH*(DATA_W+2).
- `hex_out`/`ovf` for a channel change on the clock edge ending its STORE.
- `update_done` is high during the following cycle, concurrent with the final channel's new outputs.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - At STORE, each digit above d=0 whose own value and all higher digits are 0 is driven blank.
  - Digit 0 is never blanked.
  - Blanking applies to the displayed (mod) value even when `ovf`=1.
- Undefined: every digit always shows its decimal pattern, zeros included.

## Structure
- Package `seg_pkg`:
  - FSM state enum.
  - `SEG_BLANK` and the ten digit-pattern constants, active-low form.
  - Function `bcd_to_seg(nibble, active_low)`.
- Sub-module `bin2bcd_serial`:
  - Holds the shift register, BCD accumulator, add-3 logic and sticky carry.
  - Controls: `load`, `shift`.
  - Parametrised by `DATA_W` and `DIGITS`.
- The top holds the FSM, channel counter, output registers and blanking.

## Test plan
- Defaults, `en`=1, ports {0, 99, 15} (ch2, ch1, ch0):
  - first `update_done` in cycle 103;
  - ch0 digits d1/d0 = 79/12, ch1 = 10/10, ch2 = 40/40;
  - `ovf`=000.
- ch0=100 → ch0 digits 40/40, `ovf[0]`=1. ch0=32'hFFFFFFFF → digits 10/12 (95), `ovf[0]`=1.
- Reset asserted in SHIFT cycle 10 of ch1 → next cycle: all digits 7F, `ovf`=0, `busy`=0. The refresh restarts from ch0, and `update_done` again arrives 103 cycles after release.
- `en` dropped during ch1 SHIFT → ch1 stores, then `busy`=0. Changing ch2 leaves its digits unchanged. Raising `en` resumes at ch2.
- `LEADING_ZERO_BLANK_EN` with ch0=7 → 7F/78. Without the macro → 40/78.
- NUM_CH=1, DATA_W=8, DIGITS=3, input 255 → digits 24/12/12, `ovf`=0, `update_done` period 10.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and seven-segment patterns for the output-port BCD display path.
package seg_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StStore} state_e;

  // Patterns are gfedcba, active-low (board HEX form).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble, input logic active_low);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return active_low ? seg : ~seg;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one bit per shift cycle, truncated to DIGITS nibbles with
// a sticky carry recording any bit lost off the top nibble.
module bin2bcd_serial
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_W-1:0]     bin_in,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  carry
);

  localparam int unsigned BcdW = DIGITS * 4;

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d, adj;
  logic              carry_q, carry_d;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    if (load) begin
      bin_d   = bin_in;
      bcd_d   = '0;
      carry_d = 1'b0;
    end else if (shift) begin
      // A bit leaving the top nibble means the value needs more than DIGITS digits.
      carry_d = carry_q | adj[BcdW-1];
      bcd_d   = {adj[BcdW-2:0], bin_q[DATA_W-1]};
      bin_d   = {bin_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
    end
  end

  assign bcd   = bcd_q;
  assign carry = carry_q;

endmodule

// File: rtl/out_port_bcd_seg.sv
// Round-robin binary-to-seven-segment display path for NUM_CH output ports.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module out_port_bcd_seg
  import seg_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DIGITS     = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_CH*DATA_W-1:0]   port_in,
  output logic [NUM_CH*DIGITS*7-1:0] hex_out,
  output logic [NUM_CH-1:0]          ovf,
  output logic                       busy,
  output logic                       update_done
);

  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned WordW = DIGITS * 7;
  localparam logic [6:0]  BlankPat = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_e                     state_q, state_d;
  logic [ChW-1:0]             ch_q, ch_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [NUM_CH*WordW-1:0]    hex_q, hex_d;
  logic [NUM_CH-1:0]          ovf_q, ovf_d;
  logic                       done_q, done_d;

  logic                       load, shift, carry;
  logic [DATA_W-1:0]          bin_sel;
  logic [DIGITS*4-1:0]        bcd;
  logic [WordW-1:0]           seg_word;
  logic [3:0]                 nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic                       hi_zero;
`endif

  always_comb begin
    bin_sel = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (ch_q == ChW'(k)) bin_sel = port_in[k*DATA_W +: DATA_W];
    end
  end

  bin2bcd_serial #(
    .DATA_W(DATA_W),
    .DIGITS(DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .bin_in(bin_sel),
    .bcd   (bcd),
    .carry (carry)
  );

  // Walk from the top digit down so blanking knows whether everything above is zero.
  always_comb begin
    seg_word = '0;
    nib      = '0;
`ifdef LEADING_ZERO_BLANK_EN
    hi_zero  = 1'b1;
`endif
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      nib = bcd[d*4 +: 4];
      seg_word[d*7 +: 7] = bcd_to_seg(nib, ACTIVE_LOW);
`ifdef LEADING_ZERO_BLANK_EN
      hi_zero = hi_zero & (nib == 4'd0);
      if (hi_zero && d != 0) seg_word[d*7 +: 7] = BlankPat;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        shift = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) state_d = StStore;
      end
      StStore: begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (ch_q == ChW'(k)) begin
            hex_d[k*WordW +: WordW] = seg_word;
            ovf_d[k]                = carry;
          end
        end
        if (ch_q == ChW'(NUM_CH - 1)) begin
          ch_d   = '0;
          done_d = 1'b1;
        end else begin
          ch_d = ch_q + ChW'(1);
        end
        state_d = en ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
      cnt_q   <= '0;
      hex_q   <= {(NUM_CH*DIGITS){BlankPat}};
      ovf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign hex_out     = hex_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q != StIdle);
  assign update_done = done_q;

endmodule

// File: tb/tb_out_port_bcd_seg.sv
// Scoreboard bench for out_port_bcd_seg at defaults plus a 1-channel, 8-bit, 3-digit instance.
module tb_out_port_bcd_seg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] vals [3];
  logic [95:0] port_in;
  logic [41:0] hex_out;
  logic [2:0]  ovf;
  logic        busy;
  logic        update_done;

  logic        en_s;
  logic [7:0]  port_s;
  logic [20:0] hex_s;
  logic [0:0]  ovf_s;
  logic        busy_s;
  logic        done_s;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          ch;
    logic [13:0] hex;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign port_in = {vals[2], vals[1], vals[0]};

  out_port_bcd_seg dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .port_in    (port_in),
    .hex_out    (hex_out),
    .ovf        (ovf),
    .busy       (busy),
    .update_done(update_done)
  );

  out_port_bcd_seg #(
    .NUM_CH    (1),
    .DATA_W    (8),
    .DIGITS    (3),
    .ACTIVE_LOW(1'b1)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .en         (en_s),
    .port_in    (port_s),
    .hex_out    (hex_s),
    .ovf        (ovf_s),
    .busy       (busy_s),
    .update_done(done_s)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int digit);
    case (digit)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic exp_t model(input int ch, input logic [31:0] v);
    exp_t e;
    int   m;
    logic [6:0] hi;
    m  = int'(v % 32'd100);
    hi = seg_of(m / 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (m / 10 == 0) hi = 7'h7F;
`endif
    e.ch  = ch;
    e.hex = {hi, seg_of(m % 10)};
    e.ovf = (v >= 32'd100);
    return e;
  endfunction

  task automatic push_ch(input int ch, input logic [31:0] v);
    sb_q.push_back(model(ch, v));
  endtask

  task automatic push_refresh();
    for (int k = 0; k < 3; k++) push_ch(k, vals[k]);
  endtask

  task automatic pop_compare(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 64'd0, 64'd1);
      end else begin
        e = sb_q.pop_front();
        check_val($sformatf("hex_ch%0d", e.ch), hex_out[e.ch*14 +: 14], e.hex);
        check_val($sformatf("ovf_ch%0d", e.ch), ovf[e.ch], e.ovf);
      end
    end
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!update_done && cyc < limit);
    check_val("done_seen", update_done, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_hex"}, hex_out, {6{7'h7F}});
    check_val({tag, "_ovf"}, ovf, 3'b000);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, update_done, 1'b0);
  endtask

  initial begin
    int cyc;
    reset   = 1'b1;
    en      = 1'b0;
    en_s    = 1'b1;
    port_s  = 8'd255;
    vals[0] = 32'd15;
    vals[1] = 32'd99;
    vals[2] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");

    // First refresh timed from reset release.
    reset = 1'b0;
    en    = 1'b1;
    push_refresh();
    wait_done(300, cyc);
    check_val("first_done_cycle", cyc, 103);
    check_val("busy_after_done", busy, 1'b1);
    pop_compare(3);

    // Overflow at exactly 100 and at full scale.
    vals[0] = 32'd100;
    push_refresh();
    wait_done(300, cyc);
    check_val("period_a", cyc, 102);
    pop_compare(3);

    vals[0] = 32'hFFFF_FFFF;
    push_refresh();
    wait_done(300, cyc);
    check_val("period_b", cyc, 102);
    pop_compare(3);

    vals[0] = 32'd7;
    push_refresh();
    wait_done(300, cyc);
    pop_compare(3);

    // Reset during SHIFT cycle 10 of ch1.
    wait_cycles(44);
    reset = 1'b1;
    wait_cycles(1);
    check_reset_state("mid_reset");
    reset = 1'b0;
    push_refresh();
    wait_done(300, cyc);
    check_val("done_after_reset", cyc, 103);
    pop_compare(3);

    // Drop en during ch1 SHIFT; ch1 must still complete.
    vals[1] = 32'd42;
    push_ch(0, vals[0]);
    push_ch(1, vals[1]);
    wait_cycles(40);
    en  = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (busy && cyc < 100);
    check_val("idle_after_en_drop", cyc, 28);
    pop_compare(2);

    // Idle: ch2 input change must not reach the display.
    push_ch(2, vals[2]);
    vals[2] = 32'd88;
    wait_cycles(20);
    check_val("busy_idle", busy, 1'b0);
    pop_compare(1);

    // Resume at ch2.
    en = 1'b1;
    push_ch(2, vals[2]);
    wait_done(100, cyc);
    check_val("resume_ch2_cycles", cyc, 35);
    pop_compare(1);

    // Small instance: 255 on 3 digits, period 10.
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!done_s && cyc < 50);
    check_val("small_done_seen", done_s, 1'b1);
    check_val("small_hex", hex_s, {7'h24, 7'h12, 7'h12});
    check_val("small_ovf", ovf_s, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!done_s && cyc < 50);
    check_val("small_period", cyc, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
